// File: rtl/cw_byte_packer.sv
// Packs the encoder's 11-bit codeword stream MSB-first into bytes for a valid/ready sink.
// Upstream cannot be stalled, so loss is reported on a sticky overflow flag.
module cw_byte_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] cw_in,
    input  logic        cw_rdy,
    input  logic        cw_done,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   FIFO_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [31:0]   stage_q, stage_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic          ovf_q, ovf_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          pop_s;
    logic          can_push_s;
    logic          push_s;
    logic          flushing_s;
    logic [8:0]    push_entry_s;

    // Sink handshake and push permission; a pop frees a slot for a same-cycle push.
    always_comb begin
        pop_s      = (count_q != FIFO_ZERO) && byte_ready;
        can_push_s = (count_q != FIFO_FULL) || pop_s;
    end

    // Drain one byte from staging, then append any incoming codeword behind it.
    always_comb begin
        stage_d      = stage_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        push_s       = 1'b0;
        push_entry_s = {1'b0, stage_q[31:24]};
        flushing_s   = (state_q == ST_FLUSH);

        // Outside a flush at least 8 bits stay staged so the final byte can still be tagged last.
        if (can_push_s && !flushing_s && (cnt_q >= 6'd16)) begin
            push_s  = 1'b1;
            stage_d = stage_q << 8;
            cnt_d   = cnt_q - 6'd8;
        end else if (can_push_s && flushing_s && (cnt_q != 6'd0)) begin
            push_s = 1'b1;
            if (cnt_q <= 6'd8) begin
                push_entry_s = {1'b1, stage_q[31:24]};
                stage_d      = 32'h0000_0000;
                cnt_d        = 6'd0;
            end else begin
                stage_d = stage_q << 8;
                cnt_d   = cnt_q - 6'd8;
            end
        end else begin
            push_s = 1'b0;
        end

        if (cw_rdy) begin
            if (flushing_s) begin
                ovf_d = 1'b1;
            end else if (cnt_d <= 6'd21) begin
                stage_d = stage_d | ({21'h000000, cw_in} << (6'd21 - cnt_d));
                cnt_d   = cnt_d + 6'd11;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Frame state: a done strobe arms the flush, which retires once staging is empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH: begin
                if (cnt_d == 6'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_IDLE, ST_FILL: begin
                if (cw_done) begin
                    state_d = ST_FLUSH;
                end else if (cnt_d != 6'd0) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output FIFO bookkeeping: entries hold {last, byte}.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_entry_s;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q  <= 32'h0000_0000;
            cnt_q    <= 6'd0;
            state_q  <= ST_IDLE;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: 9'h000};
            wr_ptr_q <= PTR_ONE - PTR_ONE;
            rd_ptr_q <= PTR_ONE - PTR_ONE;
            count_q  <= FIFO_ZERO;
        end else begin
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign byte_valid = (count_q != FIFO_ZERO);
    assign byte_out   = byte_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign byte_last  = byte_valid ? mem_q[rd_ptr_q][8] : 1'b0;
    assign busy       = (cnt_q != 6'd0) || (state_q == ST_FLUSH) || byte_valid;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cw_byte_packer.sv
// Directed bench for cw_byte_packer: a per-cycle vector table plus frame sequences
// whose delivered bytes are compared against hand-computed streams.
module tb_cw_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cw_in;
    logic        cw_rdy;
    logic        cw_done;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        busy;
    logic        overflow;

    cw_byte_packer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cw_in      (cw_in),
        .cw_rdy     (cw_rdy),
        .cw_done    (cw_done),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        done;
        logic [10:0] w;
        logic        rd;
        logic        ev;
        logic [7:0]  eb;
        logic        el;
        logic        ebusy;
        logic        eovf;
    } vec_t;

    vec_t       tbl [4];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [8:0] got [$];
    logic [8:0] expq [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_last  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, verify stall stability, record any handshake, advance.
    task automatic step(input logic r, input logic d, input logic [10:0] w, input logic rd);
        cw_rdy     = r;
        cw_done    = d;
        cw_in      = w;
        byte_ready = rd;
        if (prev_stall) begin
            chk("hold_valid", 32'(byte_valid), 32'd1);
            chk("hold_byte", 32'(byte_out), 32'(prev_byte));
            chk("hold_last", 32'(byte_last), 32'(prev_last));
        end
        if (byte_valid && byte_ready) got.push_back({byte_last, byte_out});
        prev_stall = byte_valid && !byte_ready;
        prev_byte  = byte_out;
        prev_last  = byte_last;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cw_rdy = 1'b0; cw_done = 1'b0; cw_in = 11'h000; byte_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        prev_stall = 1'b0;
        got.delete();
    endtask

    task automatic drain(input bit stall, input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            step(1'b0, 1'b0, 11'h000, stall ? (c % 4 == 0) : 1'b1);
            c++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_frame(input string name);
        int n;
        chk({name, "_len"}, 32'(got.size()), 32'(expq.size()));
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(expq[i]));
        end
        got.delete();
        expq.delete();
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < 4; i++) begin
            step(tbl[i].rdy, tbl[i].done, tbl[i].w, tbl[i].rd);
            chk($sformatf("%s%0d_valid", tag, i), 32'(byte_valid), 32'(tbl[i].ev));
            chk($sformatf("%s%0d_byte", tag, i), 32'(byte_out), 32'(tbl[i].eb));
            chk($sformatf("%s%0d_last", tag, i), 32'(byte_last), 32'(tbl[i].el));
            chk($sformatf("%s%0d_busy", tag, i), 32'(busy), 32'(tbl[i].ebusy));
            chk($sformatf("%s%0d_ovf", tag, i), 32'(overflow), 32'(tbl[i].eovf));
        end
        got.delete();
    endtask

    // Ten all-ones words 12 cycles apart, then done: 110 bits -> 13 x 0xFF, then 0xFC last.
    task automatic frame_ones(input bit stall, input string name);
        for (int t = 0; t <= 120; t++) begin
            step((t % 12 == 0) && (t < 120), (t == 120), 11'h7FF,
                 stall ? (t % 4 == 0) : 1'b1);
        end
        drain(stall, 400);
        for (int i = 0; i < 13; i++) expq.push_back(9'h0FF);
        expq.push_back(9'h1FC);
        check_frame(name);
        chk({name, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{rdy: 1'b1, done: 1'b1, w: 11'h555, rd: 1'b1,
                   ev: 1'b0, eb: 8'h00, el: 1'b0, ebusy: 1'b1, eovf: 1'b0};
        tbl[1] = '{rdy: 1'b0, done: 1'b0, w: 11'h000, rd: 1'b1,
                   ev: 1'b1, eb: 8'hAA, el: 1'b0, ebusy: 1'b1, eovf: 1'b0};
        tbl[2] = '{rdy: 1'b0, done: 1'b0, w: 11'h000, rd: 1'b1,
                   ev: 1'b1, eb: 8'hA0, el: 1'b1, ebusy: 1'b1, eovf: 1'b0};
        tbl[3] = '{rdy: 1'b0, done: 1'b0, w: 11'h000, rd: 1'b1,
                   ev: 1'b0, eb: 8'h00, el: 1'b0, ebusy: 1'b0, eovf: 1'b0};

        do_reset();
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte", 32'(byte_out), 32'd0);
        chk("rst_last", 32'(byte_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        apply_table("single");

        frame_ones(1'b0, "ones");
        frame_ones(1'b1, "ones_stall");

        // Back-pressured burst of 11'h001: five words fit, the rest are dropped.
        for (int t = 0; t < 10; t++) step(1'b1, 1'b0, 11'h001, 1'b0);
        chk("burst_ovf", 32'(overflow), 32'd1);
        chk("burst_valid", 32'(byte_valid), 32'd1);
        step(1'b0, 1'b1, 11'h000, 1'b1);
        drain(1'b0, 100);
        expq = '{9'h000, 9'h020, 9'h004, 9'h000, 9'h080, 9'h010, 9'h102};
        check_frame("burst");
        chk("burst_ovf_sticky", 32'(overflow), 32'd1);

        // Word arriving two cycles into a flush is dropped without disturbing the frame.
        do_reset();
        step(1'b1, 1'b0, 11'h555, 1'b1);
        step(1'b1, 1'b1, 11'h555, 1'b1);
        step(1'b0, 1'b0, 11'h000, 1'b1);
        chk("late_ovf_before", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 11'h7FF, 1'b1);
        chk("late_ovf", 32'(overflow), 32'd1);
        drain(1'b0, 100);
        expq = '{9'h0AA, 9'h0B5, 9'h154};
        check_frame("late");

        // Mid-frame reset clears everything, including the sticky overflow.
        step(1'b1, 1'b0, 11'h555, 1'b1);
        step(1'b1, 1'b0, 11'h555, 1'b1);
        step(1'b1, 1'b0, 11'h555, 1'b1);
        chk("mid_valid_pre", 32'(byte_valid), 32'd1);
        rst = 1'b1;
        cw_rdy = 1'b0; cw_done = 1'b0; byte_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(byte_valid), 32'd0);
        chk("mid_rst_byte", 32'(byte_out), 32'd0);
        chk("mid_rst_last", 32'(byte_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        prev_stall = 1'b0;
        got.delete();
        apply_table("fresh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
